// File: rtl/mandel_dual_scheduler.sv
// mandel_dual_scheduler
// Feeds pixel jobs to two mandelbrot engines (even pixels -> engine 0,
// odd pixels -> engine 1) and retires their iteration counts to the
// framebuffer write port strictly in raster order. Each engine owns a
// one-deep result slot, so at most two pixels are ahead of the retire point.
//
// Optional feature: define MANDEL_SCHED_RESTART_EN to let `start` abort a
// frame in progress. Engines busy at the abort are marked stale; their next
// completion is discarded before they receive new work.
module mandel_dual_scheduler #(
    parameter int NUM_PIXELS = 120000,
    parameter int CTRW       = 4,
    parameter int PIXW       = 17
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [1:0]      eng_run,
    output logic [PIXW-1:0] eng_px,
    input  logic [1:0]      eng_running,
    input  logic [CTRW-1:0] eng_ctr0,
    input  logic [CTRW-1:0] eng_ctr1,
    output logic            fb_reset_ptr,
    output logic            fb_write,
    output logic [CTRW-1:0] fb_wdata,
    input  logic            fb_wrote,
    output logic            busy,
    output logic            done
);
    localparam logic [PIXW-1:0] NUM_PX  = PIXW'(NUM_PIXELS);
    localparam logic [PIXW-1:0] LAST_PX = PIXW'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {FR_IDLE, FR_INIT, FR_RUN} frame_state_t;
    typedef enum logic {WR_IDLE, WR_WAIT} wr_state_t;

    frame_state_t    frame_state_reg, frame_state_next;
    wr_state_t       wr_state_reg, wr_state_next;

    logic [PIXW-1:0] disp_cnt_reg;
    logic [PIXW-1:0] retire_cnt_reg;
    logic [1:0]      inflight_reg;
    logic [1:0]      slot_valid_reg;
    logic [1:0]      l_running_reg;
    logic [CTRW-1:0] slot_data_reg [2];
    logic            fb_write_reg;
    logic [CTRW-1:0] fb_wdata_reg;
    logic            done_reg;

    logic [CTRW-1:0] eng_ctr [2];
    logic [1:0]      complete;
    logic [1:0]      eng_free;
    logic            abort;
    logic            disp_e;
    logic            disp_fire;
    logic            ret_e;
    logic            wr_ack;
    logic            last_ack;
    logic            wr_issue;
    logic [CTRW-1:0] wr_issue_data;

    assign eng_ctr[0] = eng_ctr0;
    assign eng_ctr[1] = eng_ctr1;

    // A completion is the falling edge of an engine's busy level while it
    // holds a job from the current frame.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_eng
            assign complete[gi] = inflight_reg[gi] & l_running_reg[gi] & ~eng_running[gi];
        end
    endgenerate

`ifdef MANDEL_SCHED_RESTART_EN
    logic [1:0] stale_reg;
    logic [1:0] stale_done;

    assign abort = start & (frame_state_reg != FR_IDLE);

    // A stale engine finishes a job from an aborted frame; its falling edge
    // only clears the flag and the result is dropped.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stale
            assign stale_done[gi] = stale_reg[gi] & l_running_reg[gi] & ~eng_running[gi];
        end
    endgenerate

    // Engines still working when the frame is aborted become stale; an engine
    // finishing in the abort cycle itself is already done and is not marked.
    always_ff @(posedge clk) begin
        if (reset) begin
            stale_reg <= 2'b00;
        end else begin
            stale_reg <= (stale_reg & ~stale_done)
                       | (abort ? (inflight_reg & ~complete) : 2'b00);
        end
    end

    assign eng_free = ~inflight_reg & ~slot_valid_reg & ~stale_reg;
`else
    assign abort    = 1'b0;
    assign eng_free = ~inflight_reg & ~slot_valid_reg;
`endif

    // State registers for the frame and retire machines.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_state_reg <= FR_IDLE;
            wr_state_reg    <= WR_IDLE;
        end else begin
            frame_state_reg <= frame_state_next;
            wr_state_reg    <= wr_state_next;
        end
    end

    // Next-state logic plus dispatch and retire decisions for this cycle.
    always_comb begin
        frame_state_next = frame_state_reg;
        wr_state_next    = wr_state_reg;
        disp_e           = disp_cnt_reg[0];
        ret_e            = retire_cnt_reg[0];
        disp_fire        = 1'b0;
        wr_ack           = 1'b0;
        last_ack         = 1'b0;
        wr_issue         = 1'b0;
        wr_issue_data    = '0;
        eng_run          = 2'b00;
        eng_px           = '0;

        case (frame_state_reg)
            FR_IDLE: begin
                if (start) frame_state_next = FR_INIT;
            end
            FR_INIT: begin
                frame_state_next = FR_RUN;
                wr_state_next    = WR_IDLE;
            end
            FR_RUN: begin
                disp_fire = (disp_cnt_reg < NUM_PX) && eng_free[disp_e];
                case (wr_state_reg)
                    WR_IDLE: begin
                        if (slot_valid_reg[ret_e]) begin
                            wr_issue      = 1'b1;
                            wr_issue_data = slot_data_reg[ret_e];
                            wr_state_next = WR_WAIT;
                        end
                    end
                    WR_WAIT: begin
                        // The acknowledge is only taken once the write pulse is over.
                        if (fb_wrote && !fb_write_reg) begin
                            wr_ack = 1'b1;
                            if (retire_cnt_reg == LAST_PX) begin
                                last_ack         = 1'b1;
                                wr_state_next    = WR_IDLE;
                                frame_state_next = FR_IDLE;
                            end else if (slot_valid_reg[~ret_e]) begin
                                // Next pixel is already waiting: chain the write.
                                wr_issue      = 1'b1;
                                wr_issue_data = slot_data_reg[~ret_e];
                            end else begin
                                wr_state_next = WR_IDLE;
                            end
                        end
                    end
                    default: wr_state_next = WR_IDLE;
                endcase
            end
            default: frame_state_next = FR_IDLE;
        endcase

        // An abort overrides everything else decided for this cycle.
        if (abort) begin
            frame_state_next = FR_INIT;
            wr_state_next    = WR_IDLE;
            disp_fire        = 1'b0;
            wr_issue         = 1'b0;
            last_ack         = 1'b0;
        end

        if (disp_fire) begin
            eng_run[disp_e] = 1'b1;
            eng_px          = disp_cnt_reg;
        end
    end

    // Counters, per-engine flags, result slots and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_cnt_reg     <= '0;
            retire_cnt_reg   <= '0;
            inflight_reg     <= 2'b00;
            slot_valid_reg   <= 2'b00;
            l_running_reg    <= 2'b00;
            slot_data_reg[0] <= '0;
            slot_data_reg[1] <= '0;
            fb_write_reg     <= 1'b0;
            fb_wdata_reg     <= '0;
            done_reg         <= 1'b0;
        end else begin
            l_running_reg <= eng_running;
            done_reg      <= last_ack;
            fb_write_reg  <= wr_issue;
            if (wr_issue) fb_wdata_reg <= wr_issue_data;

            if (frame_state_reg == FR_INIT) begin
                disp_cnt_reg   <= '0;
                retire_cnt_reg <= '0;
                inflight_reg   <= 2'b00;
                slot_valid_reg <= 2'b00;
            end else begin
                if (disp_fire) disp_cnt_reg   <= disp_cnt_reg + PIXW'(1);
                if (wr_ack)    retire_cnt_reg <= retire_cnt_reg + PIXW'(1);
                for (int e = 0; e < 2; e++) begin
                    if (eng_run[e])       inflight_reg[e] <= 1'b1;
                    else if (complete[e]) inflight_reg[e] <= 1'b0;

                    if (complete[e]) begin
                        slot_valid_reg[e] <= 1'b1;
                        slot_data_reg[e]  <= eng_ctr[e];
                    end else if (wr_ack && (ret_e == 1'(e))) begin
                        slot_valid_reg[e] <= 1'b0;
                    end
                end
            end
        end
    end

    assign fb_reset_ptr = (frame_state_reg == FR_INIT);
    assign fb_write     = fb_write_reg;
    assign fb_wdata     = fb_wdata_reg;
    assign busy         = (frame_state_reg != FR_IDLE);
    assign done         = done_reg;

endmodule

// File: tb/tb_mandel_dual_scheduler.sv
// tb_mandel_dual_scheduler
// Drives mandel_dual_scheduler with behavioural engine and framebuffer models.
// The reference view: pixels must be dispatched in order 0,1,2,... to engine
// (px % 2), never more than two ahead of the acknowledged count, never to a
// busy engine, and written back one at a time as ctr_tab[0], ctr_tab[1], ...
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mandel_dual_scheduler;
    localparam int NUM  = 4;
    localparam int CTRW = 4;
    localparam int PIXW = 17;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [1:0]      eng_run;
    logic [PIXW-1:0] eng_px;
    logic [1:0]      eng_running;
    logic [CTRW-1:0] eng_ctr0;
    logic [CTRW-1:0] eng_ctr1;
    logic            fb_reset_ptr;
    logic            fb_write;
    logic [CTRW-1:0] fb_wdata;
    logic            fb_wrote;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    mandel_dual_scheduler #(
        .NUM_PIXELS(NUM),
        .CTRW      (CTRW),
        .PIXW      (PIXW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .eng_run     (eng_run),
        .eng_px      (eng_px),
        .eng_running (eng_running),
        .eng_ctr0    (eng_ctr0),
        .eng_ctr1    (eng_ctr1),
        .fb_reset_ptr(fb_reset_ptr),
        .fb_write    (fb_write),
        .fb_wdata    (fb_wdata),
        .fb_wrote    (fb_wrote),
        .busy        (busy),
        .done        (done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model state
    int              cyc = 0;
    int              eng_rem [2];       // cycles of busy level still to show
    logic [CTRW-1:0] eng_val [2];       // result presented by each engine
    int              lat_cfg [2];       // busy length; 0 = random 1..6
    int              wr_cfg;            // ack delay; 0 = random 1..4
    logic [CTRW-1:0] ctr_tab [NUM];     // result for each pixel of the frame
    int              next_px;
    int              ack_cnt;
    int              done_cnt;
    int              last_ack_cyc;
    int              pend_cnt;
    bit              pend;
    logic [CTRW-1:0] pend_data;

    task automatic observe();
        int e;
        int px_i;
        for (int k = 0; k < 2; k++) if (eng_rem[k] > 0) eng_rem[k]--;

        if (eng_run != 2'b00) begin
            e    = eng_run[1] ? 1 : 0;
            px_i = int'(eng_px);
            check("run_onehot", $countones(eng_run), 1);
            check("run_px", eng_px, next_px);
            check("run_parity", eng_run[1], next_px % 2);
            check("run_window", px_i < ack_cnt + 2, 1);
            check("run_idle", eng_running[e], 0);
            eng_rem[e] = (lat_cfg[e] != 0) ? lat_cfg[e] : int'($urandom_range(1, 6));
            eng_val[e] = (next_px < NUM) ? ctr_tab[next_px] : '0;
            $display("cyc %0d: dispatch px %0d -> engine %0d", cyc, px_i, e);
            next_px++;
        end

        if (fb_wrote) begin
            check("ack_no_write", fb_write, 0);
            check("ack_data", fb_wdata, pend_data);
            $display("cyc %0d: ack pixel %0d data %0d", cyc, ack_cnt, pend_data);
            ack_cnt++;
            pend         = 1'b0;
            last_ack_cyc = cyc;
        end else if (pend) begin
            check("wdata_hold", fb_wdata, pend_data);
            pend_cnt--;
        end

        if (fb_write) begin
            check("wr_single", pend, 0);
            check("wr_in_frame", ack_cnt < NUM, 1);
            pend_data = (ack_cnt < NUM) ? ctr_tab[ack_cnt] : '0;
            check("wr_data", fb_wdata, pend_data);
            $display("cyc %0d: write pixel %0d data %0d", cyc, ack_cnt, fb_wdata);
            pend     = 1'b1;
            pend_cnt = ((wr_cfg != 0) ? wr_cfg : int'($urandom_range(1, 4))) - 1;
        end

        if (done) begin
            done_cnt++;
            check("done_after_ack", cyc - last_ack_cyc, 1);
            check("done_all_acked", ack_cnt, NUM);
            check("done_busy_low", busy, 0);
            $display("cyc %0d: done", cyc);
        end
    endtask

    task automatic cycle(input bit st, input bit rst);
        @(posedge clk);
        #1;
        start          = st;
        reset          = rst;
        eng_running[0] = (eng_rem[0] > 0);
        eng_running[1] = (eng_rem[1] > 0);
        eng_ctr0       = eng_val[0];
        eng_ctr1       = eng_val[1];
        fb_wrote       = pend && (pend_cnt == 0);
        @(negedge clk);
        cyc++;
        observe();
        if (rst) begin
            eng_rem = '{0, 0};
            pend    = 1'b0;
        end
    endtask

    task automatic new_frame_model();
        next_px  = 0;
        ack_cnt  = 0;
        done_cnt = 0;
        pend     = 1'b0;
    endtask

    task automatic begin_frame();
        new_frame_model();
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("init_reset_ptr", fb_reset_ptr, 1);
        check("init_busy", busy, 1);
        check("init_no_run", eng_run, 0);
        cycle(1'b0, 1'b0);
        check("first_run", eng_run, 2'b01);
        check("first_px", eng_px, 0);
        check("ptr_one_pulse", fb_reset_ptr, 0);
        cycle(1'b0, 1'b0);
        check("second_run", eng_run, 2'b10);
        check("second_px", eng_px, 1);
    endtask

    task automatic wait_px(input int target, input int budget, input string tag);
        int t = 0;
        while (next_px < target && t < budget) begin
            cycle(1'b0, 1'b0);
            t++;
        end
        check({tag, "_px_reached"}, next_px >= target, 1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int t = 0;
        while (done_cnt == 0 && t < budget) begin
            cycle(1'b0, 1'b0);
            t++;
        end
        check({tag, "_done_seen"}, done_cnt, 1);
        repeat (4) cycle(1'b0, 1'b0);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_acks"}, ack_cnt, NUM);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_eng_run"}, eng_run, 0);
        check({tag, "_eng_px"}, eng_px, 0);
        check({tag, "_fb_reset_ptr"}, fb_reset_ptr, 0);
        check({tag, "_fb_write"}, fb_write, 0);
        check({tag, "_fb_wdata"}, fb_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        start       = 1'b0;
        reset       = 1'b1;
        eng_running = 2'b00;
        eng_ctr0    = '0;
        eng_ctr1    = '0;
        fb_wrote    = 1'b0;
        eng_rem     = '{0, 0};
        eng_val     = '{4'd0, 4'd0};
        lat_cfg     = '{2, 2};
        wr_cfg      = 1;
        pend_cnt    = 0;
        pend_data   = '0;
        last_ack_cyc = 0;
        new_frame_model();

        repeat (3) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check_outputs_zero("reset");

        // Basic frame: engines busy 3 cycles after run, results 5..8, ack after 1 cycle.
        for (int i = 0; i < NUM; i++) ctr_tab[i] = CTRW'(5 + i);
        lat_cfg = '{2, 2};
        wr_cfg  = 1;
        begin_frame();
        wait_done(200, "basic");

        // Engine 1 finishes pixel 1 well before engine 0 finishes pixel 0.
        ctr_tab = '{4'd3, 4'd9, 4'd12, 4'd1};
        lat_cfg = '{9, 1};
        begin_frame();
        wait_done(200, "reorder");

        // Slow framebuffer: ack 20 cycles after each write.
        ctr_tab = '{4'd14, 4'd2, 4'd11, 4'd6};
        lat_cfg = '{2, 3};
        wr_cfg  = 20;
        begin_frame();
        wait_done(400, "slow_ack");

        // Reset right after pixel 2 is dispatched, then replay a full frame.
        for (int i = 0; i < NUM; i++) ctr_tab[i] = CTRW'($urandom_range(0, 15));
        lat_cfg = '{3, 3};
        wr_cfg  = 1;
        begin_frame();
        wait_px(3, 100, "midreset");
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check_outputs_zero("midreset");
        begin_frame();
        wait_done(200, "after_reset");

        // start while engine 0 is still working on pixel 2.
        for (int i = 0; i < NUM; i++) ctr_tab[i] = CTRW'(5 + i);
        lat_cfg = '{12, 2};
        wr_cfg  = 1;
        begin_frame();
        wait_px(3, 100, "restart");
        cycle(1'b1, 1'b0);
`ifdef MANDEL_SCHED_RESTART_EN
        check("abort_no_done", done_cnt, 0);
        new_frame_model();
        for (int i = 0; i < NUM; i++) ctr_tab[i] = CTRW'(9 + i);
        cycle(1'b0, 1'b0);
        check("abort_reset_ptr", fb_reset_ptr, 1);
        wait_done(300, "abort");
`else
        cycle(1'b0, 1'b0);
        check("ignored_start_ptr", fb_reset_ptr, 0);
        check("ignored_start_busy", busy, 1);
        wait_done(300, "ignored_start");
`endif

        // Randomised frames: random results, engine latencies and ack delays.
        lat_cfg = '{0, 0};
        wr_cfg  = 0;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NUM; i++) ctr_tab[i] = CTRW'($urandom_range(0, 15));
            begin_frame();
            wait_done(300, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mandel_dual_scheduler.md
# mandel_dual_scheduler

Dispatches pixel jobs to two `mandelbrot` engine instances and retires their iteration counts to the `vga_rp2040_framebuffer` write port in strict raster order. It sits between the top-level configuration/start logic and the engines/framebuffer, replacing the single-engine state machine. Throughput roughly doubles, while the write stream stays one-pixel-at-a-time with the existing `write_data`/`wrote_data` handshake.

## Interface
- `NUM_PIXELS`, 120000: pixels per frame (400×300).
- `CTRW`, 4: width of the per-pixel result written to the framebuffer.
- `PIXW`, 17: pixel index width; must satisfy 2^PIXW > NUM_PIXELS.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse; begins a frame.
- `eng_run` out 2: one-cycle run pulse per engine (bit e = engine e).
- `eng_px` out PIXW: pixel index for the engine being pulsed; valid only while an `eng_run` bit is high.
- `eng_running` in 2: engine busy levels.
- `eng_ctr0` in CTRW: engine 0 result. Sampled on the completion cycle.
- `eng_ctr1` in CTRW: engine 1 result. Sampled on the completion cycle.
- `fb_reset_ptr` out 1: one-cycle pulse; rewinds the framebuffer write pointer.
- `fb_write` out 1: one-cycle write pulse.
- `fb_wdata` out CTRW: write data; held stable from `fb_write` until `fb_wrote`.
- `fb_wrote` in 1: framebuffer acknowledge.
- `busy` out 1: high from INIT through the final retire.
- `done` out 1: one-cycle pulse after the last pixel is acknowledged.

## Operation
- Frame state machine:
  - IDLE: `start` moves it to INIT.
  - INIT: one cycle. Pulses `fb_reset_ptr` and clears all counters, flags and slots, then goes to RUN.
  - RUN: when `retire_cnt` reaches NUM_PIXELS, goes to IDLE and pulses `done`.
- Engine assignment is fixed: even pixel indices go to engine 0, odd indices to engine 1.
- Per-engine state:
  - `inflight[e]`: set on `eng_run[e]`.
  - `slot_valid[e]` and `slot_data[e]`: a one-deep result slot.
  - `l_running[e]`: registered copy of `eng_running[e]`.
- Completion of engine e is `inflight[e] & l_running[e] & ~eng_running[e]`. On completion, capture `eng_ctrE` into `slot_data[e]`, set `slot_valid[e]` and clear `inflight[e]`.
- Dispatch (RUN state only, at most one per cycle), when all of these hold:
  - `disp_cnt < NUM_PIXELS`;
  - e = `disp_cnt[0]`;
  - `!inflight[e]` and `!slot_valid[e]`.
  
  Then pulse `eng_run[e]`, drive `eng_px = disp_cnt`, set `inflight[e]`, and increment `disp_cnt`.
- Retire FSM:
  - WR_IDLE: if `slot_valid[retire_cnt[0]]`, pulse `fb_write` with that slot's data and go to WR_WAIT.
  - WR_WAIT: on `fb_wrote`, clear that slot, increment `retire_cnt`, return to WR_IDLE.
- Invariant: `retire_cnt ≤ disp_cnt ≤ retire_cnt + 2`. The framebuffer never sees out-of-order data.
- Simultaneous events are all handled in the same cycle:
  - completion of engine e and dispatch to engine e cannot coincide, because the slot must be retired first;
  - retire-clear of slot e and a completion into slot e' (e' ≠ e) both take effect;
  - `fb_wrote` and a new completion both take effect.
- `start` while `busy` is ignored unless `RESTART_EN` is defined.
- `fb_wrote` in WR_IDLE is ignored.
- Mid-operation `reset` returns the block to IDLE in the next cycle with every output 0. Engines must be reset by the same signal.

## Timing
- Reset value of every output is 0.
- Start sequence:
  - `start` high at cycle T: `fb_reset_ptr`=1 and `busy`=1 at T+1.
  - `eng_run[0]` with `eng_px`=0 at T+2.
  - `eng_run[1]` with `eng_px`=1 at T+3.
- Engine completion: `eng_running[e]` falls at cycle C; `slot_valid` is set at C+1; earliest `fb_write` is at C+2.
- `fb_wrote` is accepted no earlier than the cycle after `fb_write`.
- After `fb_wrote` at cycle A:
  - the slot is clear at A+1;
  - the next dispatch to that engine is at A+1 (the earliest);
  - the next `fb_write` is at A+1 (the earliest), if the other slot is already valid.
- `done` pulses the cycle after the final `fb_wrote`; `busy` falls the same cycle.

## Configuration
- `MANDEL_SCHED_RESTART_EN` defined:
  - `start` in INIT or RUN aborts the frame and re-enters INIT next cycle. `done` is not pulsed.
  - An engine with `inflight` set at abort gets a `stale[e]` flag. Its next completion is discarded and clears `stale[e]`, and it is not dispatched until then.
  - A pending `fb_write` handshake is abandoned.
- Undefined: `start` while `busy` has no effect and the `stale` logic is absent.

## Test plan
- NUM_PIXELS=4; engines finish 3 cycles after run with ctr 5, 6, 7, 8; `fb_wrote` 1 cycle after each write -> 4 writes with data 5, 6, 7, 8, `fb_reset_ptr` at T+1, then a `done` pulse.
- Engine 1 completes pixel 1 before engine 0 completes pixel 0 -> pixel 1 is held in its slot, and the writes are still ordered 0 then 1.
- `fb_wrote` delayed 20 cycles -> `fb_wdata` stays stable, there is no second `fb_write`, and no dispatch to an engine whose slot is still full.
- `reset` asserted mid-frame at pixel 2 -> next cycle all outputs are 0; a later `start` replays from `eng_px`=0.
- With `MANDEL_SCHED_RESTART_EN`, `start` mid-frame while engine 0 is inflight -> its result is dropped, the first write after the new `fb_reset_ptr` is pixel 0 of the new frame, and there is no `done` for the aborted frame.
- Without the macro, the same stimulus -> the frame completes unchanged and `done` pulses exactly once.
